// File: rtl/enable_ctrl_pkg.sv
// Package wrapping the shared enable_ctrl definitions plus a counter sizing helper.
package enable_ctrl_pkg;

  `include "enable_ctrl_defs.vh"

  // A 1-cycle debounce still needs a 1-bit counter to keep the logic uniform.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enable_ctrl_defs.vh
// Shared constants for enable_ctrl: FSM state encodings and default debounce length.
`ifndef ENABLE_CTRL_DEFS_VH
`define ENABLE_CTRL_DEFS_VH

localparam logic [1:0] ST_RELEASED    = 2'd0;
localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
localparam logic [1:0] ST_PRESSED     = 2'd2;
localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

localparam int EC_DB_CYCLES_DEFAULT = 4;

`endif

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reusable across blocks.
module sync_2ff (
  input  logic clk,
  input  logic r,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (r) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/enable_ctrl.sv
// Debounced push-button front end producing a registered count-enable (toggle or
// follow mode), a press strobe and the debounced level.
module enable_ctrl
  import enable_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = EC_DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic r,
  input  logic btn,
  input  logic mode,
  output logic EC,
  output logic ec_pulse,
  output logic btn_db
);

  localparam int              CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             btn_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ec_q, ec_d;
  logic             pulse_q, pulse_d;
  logic             db_q, db_d;

  sync_2ff u_sync (
    .clk (clk),
    .r   (r),
    .d   (btn),
    .q   (btn_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RELEASED: begin
        if (btn_s) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!btn_s)                state_d = ST_RELEASED;
        else if (cnt_q == CNT_LAST) state_d = ST_PRESSED;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      ST_PRESSED: begin
        if (!btn_s) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (btn_s)                 state_d = ST_PRESSED;
        else if (cnt_q == CNT_LAST) state_d = ST_RELEASED;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge
  // as the accepting transition.
  assign pulse_d = (state_q == ST_PRESS_CHK) && (state_d == ST_PRESSED);
  assign db_d    = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
  assign ec_d    = mode ? db_d : (ec_q ^ pulse_d);

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
      ec_q    <= 1'b0;
      pulse_q <= 1'b0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ec_q    <= ec_d;
      pulse_q <= pulse_d;
      db_q    <= db_d;
    end
  end

  assign EC       = ec_q;
  assign ec_pulse = pulse_q;
  assign btn_db   = db_q;

endmodule

// File: tb/tb_enable_ctrl.sv
// Scoreboard bench for enable_ctrl (DB_CYCLES=4): stimulus queues hand-derived
// per-edge expectations, a monitor pops and compares after every rising edge.
module tb_enable_ctrl;

  typedef struct {
    string nm;
    logic  db;
    logic  ec;
    logic  pu;
  } exp_t;

  logic clk;
  logic r;
  logic btn;
  logic mode;
  logic EC;
  logic ec_pulse;
  logic btn_db;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  enable_ctrl #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .r        (r),
    .btn      (btn),
    .mode     (mode),
    .EC       (EC),
    .ec_pulse (ec_pulse),
    .btn_db   (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the pushed entry describes the outputs
  // expected right after the following rising edge.
  task automatic drive(input logic r_v, input logic b_v, input logic m_v,
                       input logic db_e, input logic ec_e, input logic pu_e,
                       input string nm);
    exp_t e;
    @(negedge clk);
    r    = r_v;
    btn  = b_v;
    mode = m_v;
    e.nm = nm;
    e.db = db_e;
    e.ec = ec_e;
    e.pu = pu_e;
    exp_q.push_back(e);
  endtask

  // Monitor: every cycle presents outputs, so compare 2 time units after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (btn_db === e.db && EC === e.ec && ec_pulse === e.pu)
          n_pass++;
        else
          $display("FAIL %s: got db=%b ec=%b pulse=%b, expected db=%b ec=%b pulse=%b",
                   e.nm, btn_db, EC, ec_pulse, e.db, e.ec, e.pu);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    r        = 1'b1;
    btn      = 1'b0;
    mode     = 1'b0;

    // Reset with btn high, then first debounce after reset.
    for (int k = 1; k <= 2; k++) drive(1, 1, 0, 0, 0, 0, $sformatf("rst_hold_e%0d", k));
    for (int k = 1; k <= 10; k++)
      drive(0, 1, 0, k >= 7, k >= 7, k == 7, $sformatf("rst_release_e%0d", k));

    // Re-reset with btn low: everything back to zero, EC included.
    drive(1, 0, 0, 0, 0, 0, "rst2");

    // Glitch of 3 cycles must be rejected.
    for (int k = 1; k <= 3; k++)  drive(0, 1, 0, 0, 0, 0, $sformatf("glitch_hi_e%0d", k));
    for (int k = 1; k <= 8; k++)  drive(0, 0, 0, 0, 0, 0, $sformatf("glitch_lo_e%0d", k));

    // Clean press in toggle mode: EC 0->1, single pulse on edge 7.
    for (int k = 1; k <= 20; k++)
      drive(0, 1, 0, k >= 7, k >= 7, k == 7, $sformatf("press1_e%0d", k));
    for (int k = 1; k <= 10; k++)
      drive(0, 0, 0, k < 7, 1, 0, $sformatf("release1_e%0d", k));

    // Second press toggles EC back to 0.
    for (int k = 1; k <= 10; k++)
      drive(0, 1, 0, k >= 7, k < 7, k == 7, $sformatf("press2_e%0d", k));

    // Release bounce: 2 low cycles then high again, level held and no pulse.
    for (int k = 1; k <= 2; k++)  drive(0, 0, 0, 1, 0, 0, $sformatf("bounce_lo_e%0d", k));
    for (int k = 1; k <= 8; k++)  drive(0, 1, 0, 1, 0, 0, $sformatf("bounce_hi_e%0d", k));
    for (int k = 1; k <= 10; k++)
      drive(0, 0, 0, k < 7, 0, 0, $sformatf("release2_e%0d", k));

    // Follow mode: EC tracks btn_db on press and release.
    for (int k = 1; k <= 10; k++)
      drive(0, 1, 1, k >= 7, k >= 7, k == 7, $sformatf("follow_press_e%0d", k));
    for (int k = 1; k <= 10; k++)
      drive(0, 0, 1, k < 7, k < 7, 0, $sformatf("follow_release_e%0d", k));

    // Reset in the middle of a press debounce, then restart from scratch.
    for (int k = 1; k <= 4; k++)  drive(0, 1, 0, 0, 0, 0, $sformatf("mid_pre_e%0d", k));
    drive(1, 1, 0, 0, 0, 0, "mid_rst");
    for (int k = 1; k <= 10; k++)
      drive(0, 1, 0, k >= 7, k >= 7, k == 7, $sformatf("mid_after_e%0d", k));

    // Drain the scoreboard within a bounded number of cycles.
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enable_ctrl.md
ENABLE_CTRL -- requirements
Module: enable_ctrl

Interface
REQ-001 SHALL have parameter: DB_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a level change (legal range 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: r  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: btn  input  1  raw, asynchronous, bouncing push-button level.
REQ-005 SHALL have port: mode  input  1  0 = toggle mode, 1 = follow mode.
REQ-006 SHALL have port: EC  output  1  registered count-enable for the downstream 4-bit counter.
REQ-007 SHALL have port: ec_pulse  output  1  registered single-cycle strobe on each accepted press.
REQ-008 SHALL have port: btn_db  output  1  registered debounced button level.

Function
REQ-009 SHALL pass btn through a 2-flop synchronizer; the FSM sees only the synchronized value btn_s.
REQ-010 SHALL implement FSM states RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK; a debounce counter is cleared on every entry to a *_CHK state.
REQ-011 RELEASED: btn_s=1 -> PRESS_CHK; otherwise stay.
REQ-012 PRESS_CHK: btn_s=0 -> RELEASED (glitch rejected, no output change); btn_s=1 with counter = DB_CYCLES-1 -> PRESSED; otherwise counter +1.
REQ-013 PRESSED: btn_s=0 -> RELEASE_CHK; otherwise stay.
REQ-014 RELEASE_CHK: btn_s=1 -> PRESSED (no output change); btn_s=0 with counter = DB_CYCLES-1 -> RELEASED; otherwise counter +1.
REQ-015 btn_db SHALL be 1 exactly while in PRESSED or RELEASE_CHK; it rises on the edge PRESS_CHK->PRESSED and falls on the edge RELEASE_CHK->RELEASED.
REQ-016 Latency: with btn held stable, btn_db SHALL change after the (DB_CYCLES+3)th rising edge, counting the first edge that samples the new btn level as edge 1.
REQ-017 ec_pulse SHALL be 1 for exactly the one cycle following the PRESS_CHK->PRESSED edge and 0 otherwise; a release SHALL NOT generate a pulse.
REQ-018 mode=0: EC SHALL invert on the same edge that sets ec_pulse.
REQ-019 mode=1: EC SHALL equal btn_db, registered on the same edge as btn_db.
REQ-020 A change of mode SHALL take effect at the next edge; 1->0 retains the current EC value, 0->1 loads btn_db.
REQ-021 The debounce counter SHALL never exceed DB_CYCLES-1 and SHALL be sized for it; no wrap-around.

Reset
REQ-022 While r=1 at a rising edge: synchronizer flops 0, state RELEASED, counter 0, EC=0, ec_pulse=0, btn_db=0.
REQ-023 r SHALL have priority over all other inputs, including mid-debounce; after r falls, debouncing restarts from RELEASED using fresh synchronizer samples.

Structure
REQ-024 State encodings and the default DB_CYCLES SHALL be defined as constants in the shared definitions include file enable_ctrl_defs.vh.
REQ-025 The synchronizer SHALL be a separate sub-module sync_2ff (clk, r, d, q), reusable by other blocks.
REQ-026 All outputs SHALL be driven directly from flops.

Verification (DB_CYCLES=4)
REQ-027 SHALL verify reset: r=1 for 2 edges with btn=1 -> EC=0, btn_db=0, ec_pulse=0; after r=0, btn_db rises after the 7th edge.
REQ-028 SHALL verify a clean press: mode=0, btn 0->1 held 20 cycles -> btn_db=1 and EC 0->1 after edge 7, ec_pulse high for exactly 1 cycle.
REQ-029 SHALL verify glitch rejection: btn high for 3 cycles, then low -> btn_db, EC and ec_pulse unchanged at 0.
REQ-030 SHALL verify release bounce: from PRESSED, btn low 2 cycles then high -> btn_db stays 1 and there is no second ec_pulse.
REQ-031 SHALL verify both modes: two clean presses with mode=0 -> EC 0->1->0; then mode=1, press and release -> EC=1 after edge 7 of the press and EC=0 after edge 7 of the release.
REQ-032 SHALL verify reset mid-debounce: r=1 for 1 edge while in PRESS_CHK -> no pulse, EC=0; with btn still high, btn_db rises 7 edges after r falls.
